// File: rtl/dfr_output_reader.sv
// -----------------------------------------------------------------------------
// dfr_output_reader
//
// Reads the DFR output RAM after a run and streams each stored reservoir
// output word to the host as a sign-extended 32-bit beat over valid/ready.
// A 2-entry buffer absorbs host backpressure so that the 1-cycle RAM read
// latency never drops or duplicates a sample.
//
// Optional feature macro: DFR_READER_CHECKSUM_EN
//   defined   -> checksum is the 32-bit wrapping sum of all accepted beats
//   undefined -> checksum is tied to 0 and no accumulator is built
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high
//   start        in   one-cycle pulse, begins a readout (only honoured in IDLE)
//   num_samples  in   words to read, sampled on accepted start
//   ram_addr     out  registered RAM read address
//   ram_rdata    in   RAM read data, valid one cycle after ram_addr
//   m_data       out  head word, sign-extended to 32 bits
//   m_valid      out  beat available
//   m_ready      in   host accepts beat when m_valid && m_ready
//   m_last       out  high with the final beat
//   busy         out  readout in progress
//   done         out  one-cycle pulse after the final beat is accepted
//   checksum     out  see feature macro above
// -----------------------------------------------------------------------------
module dfr_output_reader #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 26
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   num_samples,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [31:0]           m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           checksum
);

   localparam logic [ADDR_WIDTH:0]   NUM_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   NUM_ONE  = 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;

   logic [ADDR_WIDTH:0]     r_num;       // saturated word count of this run
   logic [ADDR_WIDTH-1:0]   r_addr;      // address currently on the RAM port
   logic                    r_rd_v;      // ram_rdata holds a word still to be buffered
   logic [ADDR_WIDTH-1:0]   r_rd_idx;    // index of the word on ram_rdata
   logic                    r_wr_ptr;
   logic                    r_rd_ptr;
   logic [1:0]              r_count;     // buffer occupancy, 0..2

   logic [ADDR_WIDTH:0]     w_num_sat;
   logic [ADDR_WIDTH:0]     w_last_idx;
   logic                    w_start_accept;
   logic                    w_pop;
   logic                    w_push;
   logic [1:0]              w_occ_next;
   logic                    w_addr_is_last;
   logic                    w_rd_is_last;
   logic                    w_x_done;
   logic                    w_step;
   logic [DATA_WIDTH-1:0]   w_head_data;
   logic                    w_head_last;
   logic                    w_busy;
   logic                    w_done;

   assign w_num_sat      = (num_samples > NUM_MAX) ? NUM_MAX : num_samples;
   assign w_last_idx     = r_num - NUM_ONE;
   assign w_start_accept = (r_state == S_IDLE) && start;

   assign w_pop          = (r_count != 2'd0) && m_ready;
   assign w_push         = r_rd_v && ((r_count != 2'd2) || w_pop);
   assign w_occ_next     = r_count + {1'b0, w_push} - {1'b0, w_pop};

   assign w_addr_is_last = ({1'b0, r_addr}   == w_last_idx);
   assign w_rd_is_last   = ({1'b0, r_rd_idx} == w_last_idx);

   // The address register doubles as the stall point. The word read from
   // r_addr shows up on ram_rdata next cycle; the address may only move on if
   // that word is certain to find room in the buffer (occupancy after this
   // cycle below 2). Otherwise the address is held, so the RAM keeps
   // re-presenting the same word until a pop makes room for it.
   // w_x_done marks the held word being buffered in this cycle: the address
   // can move on, and next cycle's ram_rdata (same word again) is discarded.
   assign w_x_done = w_push && (r_rd_idx == r_addr);
   assign w_step   = (r_state == S_READ) && (w_x_done || (w_occ_next != 2'd2));

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = (num_samples == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            w_busy = 1'b1;
            if (w_step && w_addr_is_last) begin
               w_state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_busy = 1'b1;
            if (w_pop && w_head_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_done       = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign busy = w_busy;
   assign done = w_done;

   // ------------------------------------------------------------------
   // Read address, read stage and buffer control
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_num    <= '0;
         r_addr   <= '0;
         r_rd_v   <= 1'b0;
         r_rd_idx <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_start_accept) begin
            r_num  <= w_num_sat;
            r_addr <= '0;
         end else if (w_step && !w_addr_is_last) begin
            // The final address is kept on the port, so it never runs past
            // num_samples-1.
            r_addr <= r_addr + ADDR_ONE;
         end

         if (r_state == S_READ) begin
            if (w_x_done) begin
               r_rd_v <= 1'b0;
            end else begin
               r_rd_v   <= 1'b1;
               r_rd_idx <= r_addr;
            end
         end else begin
            r_rd_v <= r_rd_v && !w_push;
         end

         r_count <= w_occ_next;
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
      end
   end

   // ------------------------------------------------------------------
   // Buffer storage: one register pair per entry
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         logic [DATA_WIDTH-1:0] r_data;
         logic                  r_last;
         always_ff @(posedge clk) begin
            if (w_push && (r_wr_ptr == 1'(gi))) begin
               r_data <= ram_rdata;
               r_last <= w_rd_is_last;
            end
         end
      end
   endgenerate

   assign w_head_data = r_rd_ptr ? g_entry[1].r_data : g_entry[0].r_data;
   assign w_head_last = r_rd_ptr ? g_entry[1].r_last : g_entry[0].r_last;

   assign m_valid = (r_count != 2'd0);
   assign m_last  = m_valid && w_head_last;

   generate
      if (DATA_WIDTH < 32) begin : g_sext
         assign m_data = {{(32 - DATA_WIDTH){w_head_data[DATA_WIDTH-1]}}, w_head_data};
      end else begin : g_full
         assign m_data = w_head_data;
      end
   endgenerate

   assign ram_addr = r_addr;

   // ------------------------------------------------------------------
   // Optional checksum of accepted beats
   // ------------------------------------------------------------------
`ifdef DFR_READER_CHECKSUM_EN
   logic [31:0] r_checksum;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_checksum <= '0;
      end else if (w_start_accept) begin
         r_checksum <= '0;
      end else if (w_pop) begin
         r_checksum <= r_checksum + m_data;
      end
   end

   assign checksum = r_checksum;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_dfr_output_reader.sv
// -----------------------------------------------------------------------------
// tb_dfr_output_reader
//
// Directed bench for dfr_output_reader with a behavioural 1-cycle-latency RAM.
// A negedge monitor logs every handshake with its cycle offset from the start
// edge, counts done pulses, watches m_data stability during stalls and tracks
// the highest address presented while busy.
// -----------------------------------------------------------------------------
module tb_dfr_output_reader;

   localparam int AW = 13;
   localparam int DW = 26;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW:0]   num_samples;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_rdata;
   logic [31:0]   m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;
   logic          busy;
   logic          done;
   logic [31:0]   checksum;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] mem [0:8191];
   always @(posedge clk) ram_rdata <= mem[ram_addr];

   dfr_output_reader #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .num_samples (num_samples),
      .ram_addr    (ram_addr),
      .ram_rdata   (ram_rdata),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_last      (m_last),
      .busy        (busy),
      .done        (done),
      .checksum    (checksum)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic [31:0]   q_data [$];
   int            q_rel  [$];
   bit            q_last [$];
   int            n_done      = 0;
   int            done_rel    = -1;
   int            stab_err    = 0;
   int            t_edge      = 0;
   logic [AW-1:0] max_addr    = '0;
   bit            stall_pend  = 1'b0;
   logic [31:0]   stall_data  = '0;

   always @(negedge clk) begin
      if (reset) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend && (!m_valid || (m_data !== stall_data))) stab_err++;
         stall_pend = m_valid && !m_ready;
         stall_data = m_data;
         if (m_valid && m_ready) begin
            q_data.push_back(m_data);
            q_rel.push_back(cyc - t_edge + 1);
            q_last.push_back(m_last);
         end
         if (done) begin
            if (n_done == 0) done_rel = cyc - t_edge + 1;
            n_done++;
         end
         if (busy && (ram_addr > max_addr)) max_addr = ram_addr;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic logic [31:0] sext(input logic [DW-1:0] v);
      return {{(32 - DW){v[DW-1]}}, v};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      q_data.delete();
      q_rel.delete();
      q_last.delete();
      n_done     = 0;
      done_rel   = -1;
      stab_err   = 0;
      max_addr   = '0;
      stall_pend = 1'b0;
   endtask

   // Leaves the bench #1 into cycle T+1, where T is the start edge.
   task automatic pulse_start(input int n);
      clear_mon();
      num_samples = n[AW:0];
      start       = 1'b1;
      step();
      t_edge      = cyc;
      start       = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k = 0;
      while (n_done == 0 && k < budget) begin
         step();
         k++;
      end
      if (n_done == 0) check({tag, ".timeout"}, n_done, 1);
   endtask

   task automatic verify(input string tag, input int n_exp, input int first_rel, input int exp_done_rel);
      int agg_err = 0;
      int nl      = 0;
      check({tag, ".beats"}, q_data.size(), n_exp);
      for (int i = 0; i < q_data.size() && i < n_exp; i++) begin
         if (n_exp <= 8) begin
            check($sformatf("%s.data%0d", tag, i), q_data[i], sext(mem[i]));
            check($sformatf("%s.last%0d", tag, i), q_last[i], (i == n_exp - 1));
            if (first_rel >= 0) check($sformatf("%s.rel%0d", tag, i), q_rel[i], first_rel + i);
         end else begin
            if (q_data[i] !== sext(mem[i])) agg_err++;
            if (first_rel >= 0 && q_rel[i] != first_rel + i) agg_err++;
         end
         if (q_last[i]) nl++;
      end
      if (n_exp > 8) check({tag, ".data_rel_err"}, agg_err, 0);
      if (n_exp > 0) begin
         check({tag, ".last_cnt"}, nl, 1);
         if (q_data.size() >= n_exp) check({tag, ".last_final"}, q_last[n_exp-1], 1);
      end
      check({tag, ".done_cnt"}, n_done, 1);
      if (exp_done_rel >= 0) check({tag, ".done_rel"}, done_rel, exp_done_rel);
      check({tag, ".stable"}, stab_err, 0);
      $display("run %s: n=%0d beats=%0d done_rel=%0d max_addr=%0d checksum=0x%08h",
               tag, n_exp, q_data.size(), done_rel, max_addr, checksum);
   endtask

   // ---------------- stimulus ----------------
   bit          ready_pat [13] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1};
   logic [31:0] exp_sum;

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      num_samples = '0;
      m_ready     = 1'b0;
      for (int i = 0; i < 8192; i++) mem[i] = '0;
      step();
      step();
      step();
      reset = 1'b0;
      step();

      // Reset state
      check("rst.ram_addr", ram_addr, 0);
      check("rst.m_valid",  m_valid,  0);
      check("rst.m_last",   m_last,   0);
      check("rst.busy",     busy,     0);
      check("rst.done",     done,     0);
      check("rst.checksum", checksum, 0);

      // A: words 0..3 with ready held high
      for (int i = 0; i < 4; i++) mem[i] = DW'(i);
      m_ready = 1'b1;
      pulse_start(4);
      check("A.busy_t1",  busy,     1);
      check("A.addr_t1",  ram_addr, 0);
      check("A.valid_t1", m_valid,  0);
      wait_done("A", 50);
      verify("A", 4, 3, 7);
      check("A.busy_after", busy, 0);
`ifdef DFR_READER_CHECKSUM_EN
      check("A.checksum", checksum, 32'd6);
`else
      check("A.checksum", checksum, 32'd0);
`endif

      // G: reset while two beats sit in the buffer
      for (int i = 0; i < 6; i++) mem[i] = DW'(32'h1000 + i);
      m_ready = 1'b0;
      pulse_start(6);
      step();
      step();
      step();
      check("G.valid_pre", m_valid, 1);
      check("G.busy_pre",  busy,    1);
      reset = 1'b1;
      step();
      check("G.m_valid",  m_valid,  0);
      check("G.m_last",   m_last,   0);
      check("G.busy",     busy,     0);
      check("G.done",     done,     0);
      check("G.ram_addr", ram_addr, 0);
      check("G.checksum", checksum, 0);
      reset   = 1'b0;
      m_ready = 1'b1;
      repeat (10) step();
      check("G.no_done",  n_done,        0);
      check("G.no_beats", q_data.size(), 0);
      $display("run G: reset mid-run, beats=%0d done=%0d", q_data.size(), n_done);

      // B: sign extension of the most negative 26-bit word
      mem[0] = 26'h2000000;
      m_ready = 1'b1;
      pulse_start(1);
      wait_done("B", 50);
      verify("B", 1, 3, 4);
      if (q_data.size() > 0) check("B.m_data", q_data[0], 32'hFE000000);
`ifdef DFR_READER_CHECKSUM_EN
      check("B.checksum", checksum, 32'hFE000000);
`else
      check("B.checksum", checksum, 32'd0);
`endif

      // C: five words under a stalling host
      mem[0] = 26'h0000123;
      mem[1] = 26'h3FFFFFF;
      mem[2] = 26'h1ABCDEF;
      mem[3] = 26'h2000001;
      mem[4] = 26'h0000042;
      exp_sum = '0;
      for (int i = 0; i < 5; i++) exp_sum = exp_sum + sext(mem[i]);
      m_ready = ready_pat[0];
      pulse_start(5);
      begin
         int k = 0;
         while (n_done == 0 && k < 200) begin
            m_ready = ready_pat[k % 13];
            step();
            k++;
         end
         if (n_done == 0) check("C.timeout", n_done, 1);
      end
      verify("C", 5, -1, -1);
      check("C.max_addr", max_addr, 4);
`ifdef DFR_READER_CHECKSUM_EN
      check("C.checksum", checksum, exp_sum);
`else
      check("C.checksum", checksum, 32'd0);
`endif

      // D: zero-length readout
      m_ready = 1'b1;
      pulse_start(0);
      check("D.done_t1",  done,    1);
      check("D.valid_t1", m_valid, 0);
      check("D.busy_t1",  busy,    0);
      repeat (5) step();
      verify("D", 0, -1, 1);

      // E: a second start mid-run is ignored
      for (int i = 0; i < 8; i++) mem[i] = DW'(100 + i);
      m_ready = 1'b1;
      pulse_start(3);
      step();
      num_samples = 7;
      start       = 1'b1;
      step();
      start       = 1'b0;
      wait_done("E", 50);
      repeat (8) step();
      verify("E", 3, 3, 6);

      // F: full-depth readout
      for (int i = 0; i < 8192; i++) mem[i] = DW'(i * 8209);
      m_ready = 1'b1;
      pulse_start(8192);
      wait_done("F", 9000);
      verify("F", 8192, 3, 8195);
      check("F.max_addr", max_addr, 8191);

      // F2: oversize request saturates to full depth
      pulse_start(9000);
      wait_done("F2", 9000);
      verify("F2", 8192, 3, 8195);
      check("F2.max_addr", max_addr, 8191);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
